// File: rtl/anti_theft_fsm.sv
// Vehicle anti-theft controller: arm/disarm sequencing, entry delay countdown and timed siren.
// Optional macro STATUS_BLINK_EN: status LED blinks on each tick while ARMED instead of steady on.
module anti_theft_fsm #(
   parameter int unsigned TW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ignition,
   input  logic          door_driver,
   input  logic          door_passenger,
   input  logic          reprogram,
   input  logic          tick,
   input  logic [TW-1:0] T_ARM_DELAY,
   input  logic [TW-1:0] T_DRIVER_DELAY,
   input  logic [TW-1:0] T_PASSENGER_DELAY,
   input  logic [TW-1:0] T_ALARM_ON,
   output logic          siren,
   output logic          status,
   output logic [2:0]    state_out,
   output logic [TW-1:0] time_left
);

   typedef enum logic [2:0] {
      StArmed     = 3'd0,
      StWaitDelay = 3'd1,
      StAlarm     = 3'd2,
      StDisarmed  = 3'd3,
      StIgnOff    = 3'd4,
      StDoorOpen  = 3'd5,
      StArmWait   = 3'd6
   } state_e;

`ifdef STATUS_BLINK_EN
   localparam logic StatusRst = 1'b0;
   logic blink_d, blink_q;
`else
   localparam logic StatusRst = 1'b1;
`endif

   state_e        state_d, state_q;
   logic [TW-1:0] count_d, count_q;
   logic          siren_d, siren_q;
   logic          status_d, status_q;
   logic          any_door;
   logic          expired;
   logic [TW-1:0] count_dec;
   logic          status_armed;

   always_comb begin
      any_door  = door_driver | door_passenger;
      // A load of 0 or 1 both expire on the next tick.
      expired   = tick && (count_q <= TW'(1));
      count_dec = count_q - TW'(1);
      state_d   = state_q;
      count_d   = count_q;

      if (reprogram) begin
         state_d = StArmed;
      end else begin
         case (state_q)
            StArmed: begin
               if (door_driver) begin
                  state_d = StWaitDelay;
                  count_d = T_DRIVER_DELAY;
               end else if (door_passenger) begin
                  state_d = StWaitDelay;
                  count_d = T_PASSENGER_DELAY;
               end
            end
            StWaitDelay: begin
               if (ignition) begin
                  state_d = StDisarmed;
               end else if (expired) begin
                  state_d = StAlarm;
                  count_d = T_ALARM_ON;
               end else if (tick) begin
                  count_d = count_dec;
               end
            end
            StAlarm: begin
               if (ignition) begin
                  state_d = StDisarmed;
               end else if (any_door) begin
                  count_d = T_ALARM_ON;
               end else if (expired) begin
                  state_d = StArmed;
               end else if (tick) begin
                  count_d = count_dec;
               end
            end
            StDisarmed: begin
               if (!ignition) state_d = StIgnOff;
            end
            StIgnOff: begin
               if (ignition) state_d = StDisarmed;
               else if (door_driver) state_d = StDoorOpen;
            end
            StDoorOpen: begin
               if (ignition) begin
                  state_d = StDisarmed;
               end else if (!any_door) begin
                  state_d = StArmWait;
                  count_d = T_ARM_DELAY;
               end
            end
            StArmWait: begin
               if (ignition) state_d = StDisarmed;
               else if (any_door) state_d = StDoorOpen;
               else if (expired) state_d = StArmed;
               else if (tick) count_d = count_dec;
            end
            default: state_d = StArmed;
         endcase
      end

      // Only the timed states keep a count; everything else parks it at zero.
      if (!(state_d inside {StWaitDelay, StAlarm, StArmWait})) count_d = '0;

`ifdef STATUS_BLINK_EN
      blink_d = 1'b0;
      if (!reprogram && state_q == StArmed && state_d == StArmed) begin
         blink_d = tick ? ~blink_q : blink_q;
      end
      status_armed = blink_d;
`else
      status_armed = 1'b1;
`endif

      siren_d = (state_d == StAlarm);
      case (state_d)
         StArmed:              status_d = status_armed;
         StWaitDelay, StAlarm: status_d = 1'b1;
         default:              status_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StArmed;
         count_q  <= '0;
         siren_q  <= 1'b0;
         status_q <= StatusRst;
`ifdef STATUS_BLINK_EN
         blink_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         siren_q  <= siren_d;
         status_q <= status_d;
`ifdef STATUS_BLINK_EN
         blink_q  <= blink_d;
`endif
      end
   end

   assign siren     = siren_q;
   assign status    = status_q;
   assign state_out = state_q;
   assign time_left = count_q;

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Bench for anti_theft_fsm: directed scenarios plus randomized traffic against a reference model
// that tracks elapsed ticks against the loaded delay.
module tb_anti_theft_fsm;

   localparam int S_ARMED = 0, S_WAIT = 1, S_ALARM = 2, S_DISARMED = 3;
   localparam int S_IGN_OFF = 4, S_DOOR_OPEN = 5, S_ARM_WAIT = 6;

   logic       clk = 1'b0;
   logic       rst, ignition, door_driver, door_passenger, reprogram, tick;
   logic [3:0] t_arm, t_drv, t_pas, t_alm;
   logic       siren, status;
   logic [2:0] state_out;
   logic [3:0] time_left;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: loaded delay and ticks elapsed since load.
   int          m_state;
   int unsigned m_load, m_elapsed;
   bit          m_phase;

   anti_theft_fsm #(.TW(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .ignition          (ignition),
      .door_driver       (door_driver),
      .door_passenger    (door_passenger),
      .reprogram         (reprogram),
      .tick              (tick),
      .T_ARM_DELAY       (t_arm),
      .T_DRIVER_DELAY    (t_drv),
      .T_PASSENGER_DELAY (t_pas),
      .T_ALARM_ON        (t_alm),
      .siren             (siren),
      .status            (status),
      .state_out         (state_out),
      .time_left         (time_left)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic m_go(input int s, input int unsigned load);
      m_state   = s;
      m_load    = load;
      m_elapsed = 0;
   endtask

   function automatic bit m_expires();
      int unsigned need;
      need = (m_load == 0) ? 1 : m_load;
      return tick && (m_elapsed + 1 >= need);
   endfunction

   task automatic model_step();
      int prev;
      bit door_any;
      prev     = m_state;
      door_any = door_driver || door_passenger;
      if (rst || reprogram) begin
         m_go(S_ARMED, 0);
         m_phase = 0;
      end else begin
         case (m_state)
            S_ARMED:
               if (door_driver) m_go(S_WAIT, t_drv);
               else if (door_passenger) m_go(S_WAIT, t_pas);
               else if (tick) m_phase = !m_phase;
            S_WAIT:
               if (ignition) m_go(S_DISARMED, 0);
               else if (m_expires()) m_go(S_ALARM, t_alm);
               else if (tick) m_elapsed++;
            S_ALARM:
               if (ignition) m_go(S_DISARMED, 0);
               else if (door_any) m_go(S_ALARM, t_alm);
               else if (m_expires()) m_go(S_ARMED, 0);
               else if (tick) m_elapsed++;
            S_DISARMED:
               if (!ignition) m_go(S_IGN_OFF, 0);
            S_IGN_OFF:
               if (ignition) m_go(S_DISARMED, 0);
               else if (door_driver) m_go(S_DOOR_OPEN, 0);
            S_DOOR_OPEN:
               if (ignition) m_go(S_DISARMED, 0);
               else if (!door_any) m_go(S_ARM_WAIT, t_arm);
            S_ARM_WAIT:
               if (ignition) m_go(S_DISARMED, 0);
               else if (door_any) m_go(S_DOOR_OPEN, 0);
               else if (m_expires()) m_go(S_ARMED, 0);
               else if (tick) m_elapsed++;
            default: m_go(S_ARMED, 0);
         endcase
         if (m_state == S_ARMED && prev != S_ARMED) m_phase = 0;
      end
   endtask

   function automatic bit m_status();
      if (m_state == S_WAIT || m_state == S_ALARM) return 1'b1;
      if (m_state != S_ARMED) return 1'b0;
`ifdef STATUS_BLINK_EN
      return m_phase;
`else
      return 1'b1;
`endif
   endfunction

   // One clock: model follows the edge, outputs sampled 1 time unit later.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_eq("state", state_out, m_state);
      check_eq("siren", siren, (m_state == S_ALARM) ? 1 : 0);
      check_eq("status", status, m_status());
      check_eq("time_left", time_left, m_load - m_elapsed);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         cycle();
         tick = 1'b0;
         cycle();
      end
   endtask

   initial begin
      rst = 1'b1; ignition = 1'b0; door_driver = 1'b0; door_passenger = 1'b0;
      reprogram = 1'b0; tick = 1'b0;
      t_arm = 4'd6; t_drv = 4'd8; t_pas = 4'd5; t_alm = 4'd3;
      m_go(S_ARMED, 0);
      m_phase = 0;
      cycle();
      cycle();
      check_eq("rst_state", state_out, S_ARMED);
      check_eq("rst_time_left", time_left, 0);
      check_eq("rst_siren", siren, 0);
      rst = 1'b0;

      // Driver entry, delay 8, expires into alarm.
      door_driver = 1'b1;
      cycle();
      check_eq("drv_wait_state", state_out, S_WAIT);
      check_eq("drv_wait_tl", time_left, 8);
      ticks(8);
      check_eq("alarm_state", state_out, S_ALARM);
      check_eq("alarm_siren", siren, 1);
      check_eq("alarm_tl", time_left, 3);

      // Doors held open keep the siren going; closed doors let it time out.
      door_passenger = 1'b1;
      ticks(5);
      check_eq("alarm_held_siren", siren, 1);
      door_driver = 1'b0; door_passenger = 1'b0;
      ticks(3);
      check_eq("alarm_done_state", state_out, S_ARMED);
      check_eq("alarm_done_siren", siren, 0);

      // Passenger entry disarmed by ignition, then a full re-arm sequence.
      door_passenger = 1'b1;
      cycle();
      check_eq("pas_wait_tl", time_left, 5);
      door_passenger = 1'b0;
      ticks(2);
      ignition = 1'b1;
      cycle();
      check_eq("disarmed_state", state_out, S_DISARMED);
      check_eq("disarmed_siren", siren, 0);
      ignition = 1'b0;
      cycle();
      check_eq("ign_off_state", state_out, S_IGN_OFF);
      door_driver = 1'b1;
      cycle();
      check_eq("door_open_state", state_out, S_DOOR_OPEN);
      door_driver = 1'b0;
      cycle();
      check_eq("arm_wait_tl", time_left, 6);
      ticks(6);
      check_eq("rearmed_state", state_out, S_ARMED);

      // Door opened in ARM_WAIT with 2 ticks left restarts the full arm delay.
      door_driver = 1'b1; cycle(); door_driver = 1'b0;
      ignition = 1'b1; cycle(); ignition = 1'b0; cycle();
      door_driver = 1'b1; cycle(); door_driver = 1'b0; cycle();
      ticks(4);
      check_eq("arm_wait_left2", time_left, 2);
      door_passenger = 1'b1;
      cycle();
      check_eq("arm_wait_reopen", state_out, S_DOOR_OPEN);
      door_passenger = 1'b0;
      cycle();
      check_eq("arm_wait_reload", time_left, 6);
      t_arm = 4'd9;
      ticks(1);
      check_eq("arm_wait_no_relatch", time_left, 5);
      ticks(5);

      // Zero driver delay alarms on the first tick; reprogram clears the alarm.
      t_drv = 4'd0;
      door_driver = 1'b1; cycle(); door_driver = 1'b0;
      check_eq("zero_delay_tl", time_left, 0);
      ticks(1);
      check_eq("zero_delay_alarm", state_out, S_ALARM);
      reprogram = 1'b1; cycle(); reprogram = 1'b0;
      check_eq("reprog_state", state_out, S_ARMED);
      check_eq("reprog_siren", siren, 0);
      t_drv = 4'd2; t_pas = 4'd9;
      door_driver = 1'b1; door_passenger = 1'b1; cycle();
      door_driver = 1'b0; door_passenger = 1'b0;
      check_eq("both_doors_tl", time_left, 2);
      rst = 1'b1; cycle(); rst = 1'b0;
      check_eq("rst_wait_state", state_out, S_ARMED);
      check_eq("rst_wait_tl", time_left, 0);

      // ARMED indicator across four ticks.
      for (int i = 0; i < 4; i++) begin
         tick = 1'b1; cycle(); tick = 1'b0;
`ifdef STATUS_BLINK_EN
         check_eq("blink", status, (i % 2 == 0) ? 1 : 0);
`else
         check_eq("steady", status, 1);
`endif
         cycle();
      end

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         rst       = ($urandom_range(0, 199) == 0);
         reprogram = ($urandom_range(0, 99) == 0);
         tick      = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 19) == 0) ignition = ~ignition;
         if ($urandom_range(0, 7) == 0) door_driver = ~door_driver;
         if ($urandom_range(0, 7) == 0) door_passenger = ~door_passenger;
         if ($urandom_range(0, 29) == 0) t_arm = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 29) == 0) t_drv = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 29) == 0) t_pas = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 29) == 0) t_alm = 4'($urandom_range(0, 15));
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
